hdc_am_search_fsm: RTL
======================

# hdc_am_search_fsm

Associative-memory search controller on the query side of the sparse HDC pipeline: the read-out counterpart of the encoding FSM. On a start pulse (the encoder's done flag), it steps through every stored class hypervector segment by segment. For each class it accumulates the overlap popcount(query & class) and keeps the running argmax. When every class has been scored it reports the predicted class and its similarity. Sits between the encoder/query register and the class-hypervector memory.

## Interface
- NUM_CLASSES, 10, number of stored class hypervectors (≥2)
- NUM_SEGS, 16, segments per hypervector (≥2)
- SEG_W, 64, bits per segment
- CLS_W, $clog2(NUM_CLASSES), class index width
- SEG_AW, $clog2(NUM_SEGS), segment address width
- SIM_W, $clog2(NUM_SEGS*SEG_W+1), similarity width
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- en  in  1  global enable; low = freeze
- start_search  in  1  start request, sampled only in S_IDLE/S_DONE
- query_seg  in  SEG_W  query segment at seg_addr, valid cycle after mem_rd_en
- class_seg  in  SEG_W  class memory data for {class_addr, seg_addr}, valid cycle after mem_rd_en
- mem_rd_en  out  1  read strobe to class memory / query mux
- class_addr  out  CLS_W  class being scored
- seg_addr  out  SEG_AW  segment being read
- busy  out  1  search in progress (any state except S_IDLE/S_DONE)
- search_done  out  1  result valid; held until next accepted start
- pred_class  out  CLS_W  index of best class
- pred_sim  out  SIM_W  overlap of best class

## Operation
- States: S_IDLE, S_READ, S_LAST, S_CMP, S_DONE.
- S_IDLE/S_DONE: start_search && en -> S_READ. On that transition: class_addr=0, seg_addr=0, acc=0, best_sim=0, best_class=0. search_done drops.
- S_READ: mem_rd_en = en. Each cycle with mem_rd_en, seg_addr increments. With mem_rd_en && seg_addr==NUM_SEGS-1 -> S_LAST; seg_addr wraps to 0.
- rd_valid register = mem_rd_en delayed one cycle. Whenever rd_valid is high, acc += popcount(query_seg & class_seg). Accumulation happens regardless of en, so an in-flight read is never lost.
- S_LAST (en): absorbs the final segment via rd_valid -> S_CMP.
- S_CMP (en): if class_addr==0 or acc > best_sim, load best_sim=acc and best_class=class_addr. Strict greater-than, so ties keep the lower index. Clear acc.
  - If class_addr==NUM_CLASSES-1 -> S_DONE, with pred_class=best_class updated value and pred_sim=best_sim updated value.
  - Else class_addr++ -> S_READ.
- S_DONE: search_done=1; pred_* held stable.
- start_search while busy: ignored.
- en low in S_READ/S_LAST/S_CMP: state, addresses, best_* and counters hold; mem_rd_en=0.
- Arithmetic: acc and best_sim are SIM_W unsigned; per-segment popcount is width $clog2(SEG_W+1), zero-extended. acc cannot overflow by construction.

## Timing
- Reset values: state S_IDLE; mem_rd_en=0, class_addr=0, seg_addr=0, busy=0, search_done=0, pred_class=0, pred_sim=0. Internal acc, best_*, rd_valid are 0.
- Async reset mid-search returns to S_IDLE immediately and discards partial results.
- Outputs are registered/state-decoded; no combinational path from inputs except mem_rd_en = en && state==S_READ.
- Memory latency is fixed at 1 cycle. Data for the address presented with mem_rd_en at edge N is sampled at edge N+1.
- Per class with en held high: NUM_SEGS + 2 cycles (READ×NUM_SEGS, LAST, CMP).
- Start sampled at edge E0; search_done is high after edge E0 + NUM_CLASSES*(NUM_SEGS+2), plus one cycle for each cycle en is low while busy.
- A start accepted in S_DONE drops search_done at the next edge; pred_* keep their old values until the new S_CMP of the last class.

## Test plan
Use NUM_CLASSES=4, NUM_SEGS=4, SEG_W=8 and a memory model with 1-cycle latency.
- Reset: assert nrst low mid-cycle -> all outputs 0 immediately; after release, state S_IDLE, busy=0.
- Basic: query all 8'hFF; class c segments popcounts {c=0:2, 1:5, 2:9, 3:4} per vector -> after 24 edges search_done=1, pred_class=2, pred_sim=9, busy=0.
- Tie: class overlaps {3,7,1,7} -> pred_class=1, pred_sim=7. All-zero query -> pred_class=0, pred_sim=0.
- en gap: drop en for 3 cycles during S_READ of class 1, including the cycle after a read -> same pred_class/pred_sim as the no-gap run, done at edge 27; no duplicated or dropped segment.
- Restart/ignore: pulse start_search at edge 10 (busy) -> no effect, done still at edge 24. Start again in S_DONE with different memory -> search_done low next cycle, new result after 24 more edges.
- Reset mid-search at edge 13, then start -> correct result 24 edges after new start, no residue from the aborted run.

Source files
------------

// File: rtl/hdc_am_search_fsm.sv
// Associative-memory search controller: scores every stored class hypervector
// against the query (overlap = popcount(query & class)) and keeps the running argmax.
// Memory reads have a fixed 1-cycle latency; en low freezes the walk, but a read already in flight is still accumulated.
module hdc_am_search_fsm #(
  parameter int NUM_CLASSES = 10,
  parameter int NUM_SEGS    = 16,
  parameter int SEG_W       = 64,
  parameter int CLS_W       = $clog2(NUM_CLASSES),
  parameter int SEG_AW      = $clog2(NUM_SEGS),
  parameter int SIM_W       = $clog2(NUM_SEGS*SEG_W+1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              start_search,
  input  logic [SEG_W-1:0]  query_seg,
  input  logic [SEG_W-1:0]  class_seg,
  output logic              mem_rd_en,
  output logic [CLS_W-1:0]  class_addr,
  output logic [SEG_AW-1:0] seg_addr,
  output logic              busy,
  output logic              search_done,
  output logic [CLS_W-1:0]  pred_class,
  output logic [SIM_W-1:0]  pred_sim
);

  localparam int PC_W = $clog2(SEG_W+1);
  localparam logic [CLS_W-1:0]  LAST_CLS = CLS_W'(NUM_CLASSES-1);
  localparam logic [SEG_AW-1:0] LAST_SEG = SEG_AW'(NUM_SEGS-1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_LAST = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Control strobes produced by the next-state logic.
  logic start_accept;
  logic cmp_fire;

  // Datapath state.
  logic             rd_valid;
  logic [SIM_W-1:0] acc;
  logic [SIM_W-1:0] best_sim;
  logic [CLS_W-1:0] best_class;
  logic             new_best;
  logic [PC_W-1:0]  seg_pop;

  function automatic logic [PC_W-1:0] popcnt(input logic [SEG_W-1:0] v);
    logic [PC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < SEG_W; i++) begin
      cnt = cnt + PC_W'(v[i]);
    end
    return cnt;
  endfunction

  // Overlap contributed by the segment returned this cycle.
  always_comb begin
    seg_pop = popcnt(query_seg & class_seg);
  end

  // Class 0 always seeds the argmax; later classes must strictly beat it, so ties keep the lower index.
  always_comb begin
    new_best = (class_addr == '0) || (acc > best_sim);
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the only combinational output (the read strobe).
  always_comb begin
    state_nxt    = state;
    start_accept = 1'b0;
    cmp_fire     = 1'b0;
    mem_rd_en    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (en && start_search) begin
          state_nxt    = S_READ;
          start_accept = 1'b1;
        end
      end
      S_READ: begin
        mem_rd_en = en;
        if (en && (seg_addr == LAST_SEG)) begin
          state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        // Wait one cycle so the last segment's data is absorbed into acc.
        if (en) begin
          state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (en) begin
          cmp_fire  = 1'b1;
          state_nxt = (class_addr == LAST_CLS) ? S_DONE : S_READ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    busy        = (state == S_READ) || (state == S_LAST) || (state == S_CMP);
    search_done = (state == S_DONE);
  end

  // Read-data valid tracks the read strobe with the memory's fixed 1-cycle latency.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= mem_rd_en;
    end
  end

  // Segment address walks 0..NUM_SEGS-1 once per class and wraps for the next one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg_addr <= '0;
    end else if (start_accept) begin
      seg_addr <= '0;
    end else if (mem_rd_en) begin
      seg_addr <= (seg_addr == LAST_SEG) ? '0 : seg_addr + 1'b1;
    end
  end

  // Class address advances after each comparison except the final one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      class_addr <= '0;
    end else if (start_accept) begin
      class_addr <= '0;
    end else if (cmp_fire && (class_addr != LAST_CLS)) begin
      class_addr <= class_addr + 1'b1;
    end
  end

  // Overlap accumulator; accumulates independent of en so in-flight data is never dropped.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc <= '0;
    end else if (start_accept || cmp_fire) begin
      acc <= '0;
    end else if (rd_valid) begin
      acc <= acc + SIM_W'(seg_pop);
    end
  end

  // Running argmax over the classes scored so far.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      best_sim   <= '0;
      best_class <= '0;
    end else if (start_accept) begin
      best_sim   <= '0;
      best_class <= '0;
    end else if (cmp_fire && new_best) begin
      best_sim   <= acc;
      best_class <= class_addr;
    end
  end

  // Published result: updated only at the last class's compare, otherwise held (also across a restart).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pred_class <= '0;
      pred_sim   <= '0;
    end else if (cmp_fire && (class_addr == LAST_CLS)) begin
      pred_class <= new_best ? class_addr : best_class;
      pred_sim   <= new_best ? acc : best_sim;
    end
  end

endmodule
